// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg : constants shared by the instruction-fetch stage
// Revision     : 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int unsigned       C_XLEN            = 32;
    localparam logic [C_XLEN-1:0] NOP_INST          = 32'h0000_0000;
    localparam logic [C_XLEN-1:0] PC_INC            = 32'd4;
    localparam logic [C_XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    // Source of the next program counter.
    typedef enum logic [1:0] {
        PC_SRC_HOLD   = 2'd0,
        PC_SRC_SEQ    = 2'd1,
        PC_SRC_BRANCH = 2'd2,
        PC_SRC_JUMP   = 2'd3
    } pc_src_e;

endpackage

`default_nettype wire

// File: rtl/pc_register.sv
// ============================================================================
// pc_register : WIDTH-bit program counter with write enable, async reset
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_register
    import if_stage_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (we_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : MIPS instruction fetch - PC, next-PC select, IF/ID register,
//            saturating stall/flush debug counters
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             IF_ID_write,
    input  logic             flush,
    input  logic             jump,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] inst_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] IF_ID_inst,
    output logic [WIDTH-1:0] IF_ID_pc_plus4,
    output logic             IF_ID_valid,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic             stall;
    logic             flush_acc;
    pc_src_e          pc_src;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_d;

    logic [WIDTH-1:0] inst_q,   inst_d;
    logic [WIDTH-1:0] pc4_q,    pc4_d;
    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] stall_q,  stall_d;
    logic [CNT_W-1:0] flush_q,  flush_d;

    // A stalled branch has unresolved operands, so stall outranks flush.
    assign stall     = !pc_write || !IF_ID_write;
    assign flush_acc = flush && !stall;
    assign pc_plus4  = pc_q + WIDTH'(PC_INC);

    always_comb begin
        pc_src = PC_SRC_SEQ;
        if (stall) begin
            pc_src = PC_SRC_HOLD;
        end else if (flush) begin
            pc_src = jump ? PC_SRC_JUMP : PC_SRC_BRANCH;
        end
    end

    always_comb begin
        pc_d = pc_plus4;
        case (pc_src)
            PC_SRC_HOLD:   pc_d = pc_q;
            PC_SRC_BRANCH: pc_d = branch_target;
            PC_SRC_JUMP:   pc_d = jump_target;
            default:       pc_d = pc_plus4;
        endcase
    end

    pc_register #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk  (clk),
        .rst  (rst),
        .we_i (!stall),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    // With pc_write low but IF_ID_write high, IF/ID reloads the same fetch.
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (IF_ID_write) begin
            if (flush_acc) begin
                inst_d  = WIDTH'(NOP_INST);
                pc4_d   = '0;
                valid_d = 1'b0;
            end else begin
                inst_d  = inst_in;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_acc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= WIDTH'(NOP_INST);
            pc4_q   <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign pc_out         = pc_q;
    assign IF_ID_inst     = inst_q;
    assign IF_ID_pc_plus4 = pc4_q;
    assign IF_ID_valid    = valid_q;
    assign stall_cycles   = stall_q;
    assign flush_count    = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed self-checking bench for if_stage (CNT_W 16 and 2)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, IF_ID_write, flush, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] inst_in, inst_in_s;
    logic [31:0] pc_out, IF_ID_inst, IF_ID_pc_plus4;
    logic        IF_ID_valid;
    logic [15:0] stall_cycles, flush_count;
    logic [31:0] pc_out_s, IF_ID_inst_s, IF_ID_pc_plus4_s;
    logic        IF_ID_valid_s;
    logic [1:0]  stall_cycles_s, flush_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: the word at address p is p itself.
    assign inst_in   = pc_out;
    assign inst_in_s = pc_out_s;

    if_stage #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .flush(flush), .jump(jump), .branch_target(branch_target),
        .jump_target(jump_target), .inst_in(inst_in), .pc_out(pc_out),
        .IF_ID_inst(IF_ID_inst), .IF_ID_pc_plus4(IF_ID_pc_plus4),
        .IF_ID_valid(IF_ID_valid), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    if_stage #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .flush(flush), .jump(jump), .branch_target(branch_target),
        .jump_target(jump_target), .inst_in(inst_in_s), .pc_out(pc_out_s),
        .IF_ID_inst(IF_ID_inst_s), .IF_ID_pc_plus4(IF_ID_pc_plus4_s),
        .IF_ID_valid(IF_ID_valid_s), .stall_cycles(stall_cycles_s),
        .flush_count(flush_count_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_out, 32'h0); end
        checks++; if (IF_ID_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp %h", IF_ID_inst, 32'h0); end
        checks++; if (IF_ID_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h exp %h", IF_ID_pc_plus4, 32'h0); end
        checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", IF_ID_valid); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", stall_cycles, flush_count); end
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL run_pc0: got %h exp %h", pc_out, 32'h0); end
        step();
        checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL run_pc1: got %h exp %h", pc_out, 32'h4); end
        checks++; if (IF_ID_inst !== 32'h0 || IF_ID_pc_plus4 !== 32'h4 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL run_ifid1: got %h/%h/%b exp 0/4/1", IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
        step();
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL run_pc2: got %h exp %h", pc_out, 32'h8); end
        checks++; if (IF_ID_inst !== 32'h4 || IF_ID_pc_plus4 !== 32'h8) begin errors++; $display("FAIL run_ifid2: got %h/%h exp 4/8", IF_ID_inst, IF_ID_pc_plus4); end
    endtask

    task automatic test_stall();
        pc_write = 1'b0; IF_ID_write = 1'b0;
        step();
        checks++; if (pc_out !== 32'h8 || stall_cycles !== 16'd1) begin errors++; $display("FAIL stall1: got pc %h cnt %0d exp 8/1", pc_out, stall_cycles); end
        step();
        checks++; if (pc_out !== 32'h8 || stall_cycles !== 16'd2) begin errors++; $display("FAIL stall2: got pc %h cnt %0d exp 8/2", pc_out, stall_cycles); end
        checks++; if (IF_ID_inst !== 32'h4 || IF_ID_pc_plus4 !== 32'h8 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got %h/%h/%b exp 4/8/1", IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
        checks++; if (stall_cycles_s !== 2'd2) begin errors++; $display("FAIL stall_small: got %0d exp 2", stall_cycles_s); end
        idle_inputs();
        step();
        checks++; if (pc_out !== 32'hC || IF_ID_inst !== 32'h8 || IF_ID_pc_plus4 !== 32'hC) begin errors++; $display("FAIL stall_resume: got pc %h inst %h pc4 %h exp C/8/C", pc_out, IF_ID_inst, IF_ID_pc_plus4); end
    endtask

    task automatic test_flush();
        step();
        checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL flush_pre: got %h exp %h", pc_out, 32'h10); end
        flush = 1'b1; jump = 1'b0; branch_target = 32'h40; jump_target = 32'h100;
        step();
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h exp %h", pc_out, 32'h40); end
        checks++; if (IF_ID_inst !== 32'h0 || IF_ID_pc_plus4 !== 32'h0 || IF_ID_valid !== 1'b0) begin errors++; $display("FAIL branch_bubble: got %h/%h/%b exp 0/0/0", IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
        checks++; if (flush_count !== 16'd1 || stall_cycles !== 16'd2) begin errors++; $display("FAIL branch_cnt: got f%0d s%0d exp f1 s2", flush_count, stall_cycles); end
        idle_inputs();
        step();
        checks++; if (pc_out !== 32'h44 || IF_ID_inst !== 32'h40 || IF_ID_pc_plus4 !== 32'h44 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL branch_target_fetch: got pc %h inst %h pc4 %h v %b exp 44/40/44/1", pc_out, IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
    endtask

    task automatic test_jump();
        flush = 1'b1; jump = 1'b1; branch_target = 32'h40; jump_target = 32'h200;
        step();
        checks++; if (pc_out !== 32'h200 || flush_count !== 16'd2) begin errors++; $display("FAIL jump_pc: got pc %h f%0d exp 200/2", pc_out, flush_count); end
        idle_inputs();
        step();
        checks++; if (pc_out !== 32'h204 || IF_ID_inst !== 32'h200 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL jump_fetch: got pc %h inst %h v %b exp 204/200/1", pc_out, IF_ID_inst, IF_ID_valid); end
    endtask

    task automatic test_stall_over_flush();
        flush = 1'b1; jump = 1'b1; jump_target = 32'h100; pc_write = 1'b0; IF_ID_write = 1'b1;
        step();
        checks++; if (pc_out !== 32'h204) begin errors++; $display("FAIL sof_pc: got %h exp %h", pc_out, 32'h204); end
        checks++; if (flush_count !== 16'd2 || stall_cycles !== 16'd3) begin errors++; $display("FAIL sof_cnt: got f%0d s%0d exp f2 s3", flush_count, stall_cycles); end
        checks++; if (IF_ID_inst !== 32'h204 || IF_ID_pc_plus4 !== 32'h208 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL sof_reload: got %h/%h/%b exp 204/208/1", IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
        checks++; if (stall_cycles_s !== 2'd3 || flush_count_s !== 2'd2) begin errors++; $display("FAIL sof_small: got s%0d f%0d exp s3 f2", stall_cycles_s, flush_count_s); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        pc_write = 1'b0; IF_ID_write = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (stall_cycles !== 16'd8) begin errors++; $display("FAIL sat_stall_wide: got %0d exp 8", stall_cycles); end
        checks++; if (stall_cycles_s !== 2'd3) begin errors++; $display("FAIL sat_stall_small: got %0d exp 3", stall_cycles_s); end
        checks++; if (pc_out !== 32'h204) begin errors++; $display("FAIL sat_pc_hold: got %h exp %h", pc_out, 32'h204); end
        idle_inputs();
        flush = 1'b1; branch_target = 32'h10;
        step();
        step();
        checks++; if (flush_count !== 16'd4 || flush_count_s !== 2'd3) begin errors++; $display("FAIL sat_flush: got %0d/%0d exp 4/3", flush_count, flush_count_s); end
        checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL sat_flush_pc: got %h exp %h", pc_out, 32'h10); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        flush = 1'b1; jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load: got %h exp %h", pc_out, 32'hFFFF_FFFC); end
        idle_inputs();
        step();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp %h", pc_out, 32'h0); end
        checks++; if (IF_ID_inst !== 32'hFFFF_FFFC || IF_ID_pc_plus4 !== 32'h0 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h/%h/%b exp FFFFFFFC/0/1", IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
        step();
    endtask

    task automatic test_async_reset();
        pc_write = 1'b0; IF_ID_write = 1'b0;
        step();
        checks++; if (pc_out !== 32'h4 || stall_cycles !== 16'd9) begin errors++; $display("FAIL ar_pre: got pc %h s%0d exp 4/9", pc_out, stall_cycles); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h exp %h", pc_out, 32'h0); end
        checks++; if (IF_ID_inst !== 32'h0 || IF_ID_pc_plus4 !== 32'h0 || IF_ID_valid !== 1'b0) begin errors++; $display("FAIL ar_ifid: got %h/%h/%b exp 0/0/0", IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0 || stall_cycles_s !== 2'd0 || flush_count_s !== 2'd0) begin errors++; $display("FAIL ar_cnt: got %0d/%0d/%0d/%0d exp 0/0/0/0", stall_cycles, flush_count, stall_cycles_s, flush_count_s); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (pc_out !== 32'h4 || IF_ID_inst !== 32'h0 || IF_ID_pc_plus4 !== 32'h4 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL ar_restart: got pc %h inst %h pc4 %h v %b exp 4/0/4/1", pc_out, IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_flush();
        test_jump();
        test_stall_over_flush();
        test_saturation();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
